// File: rtl/tone_synth_nch.sv
// rtl/tone_synth_nch.sv - NCH-voice square-wave tone synthesiser with saturated signed mix
// Each voice plays a timed square wave loaded by a valid/ready command, then pulses done.
module tone_synth_nch #(
    parameter int NCH   = 2,
    parameter int DIV_W = 22,
    parameter int DUR_W = 24,
    parameter int AUD_W = 16,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CHW-1:0]       cmd_ch,
    input  logic [DIV_W-1:0]     cmd_div,
    input  logic [DUR_W-1:0]     cmd_dur,
    input  logic [AUD_W-2:0]     cmd_amp,
    input  logic                 stop_all,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic                 cmd_err,
    output logic [NCH*AUD_W-1:0] audio_ch,
    output logic [AUD_W-1:0]     audio_mix
);
    localparam int SW = AUD_W + CHW + 1;
    localparam logic signed [SW-1:0] SAT_MAX = {{(CHW+2){1'b0}}, {(AUD_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(CHW+2){1'b1}}, {(AUD_W-1){1'b0}}};

    typedef enum logic {S_IDLE, S_PLAY} state_e;

    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [DIV_W-1:0] div_q   [NCH];
    logic [DIV_W-1:0] div_d   [NCH];
    logic [DIV_W-1:0] phase_q [NCH];
    logic [DIV_W-1:0] phase_d [NCH];
    logic [DUR_W-1:0] dur_q   [NCH];
    logic [DUR_W-1:0] dur_d   [NCH];
    logic [AUD_W-2:0] amp_q   [NCH];
    logic [AUD_W-2:0] amp_d   [NCH];
    logic [NCH-1:0]   pol_q, pol_d;
    logic [NCH-1:0]   done_q, done_d;
    logic             cmd_err_q, cmd_err_d;
    logic [AUD_W-1:0] mix_q, mix_d;

    logic             ch_ok;
    logic             tgt_idle;
    logic             accept;
    logic [AUD_W-1:0] mag;
    logic [AUD_W-1:0] smp;
    logic signed [SW-1:0] sum;

    // Out-of-range channels are always "ready" so a bad command is consumed and flagged.
    always_comb begin
        ch_ok    = 1'b0;
        tgt_idle = 1'b0;
        for (int v = 0; v < NCH; v++) begin
            if (cmd_ch == CHW'(v)) begin
                ch_ok    = 1'b1;
                tgt_idle = (state_q[v] == S_IDLE);
            end
        end
        cmd_ready = !stop_all && (!ch_ok || tgt_idle);
        accept    = cmd_valid && cmd_ready;
    end

    always_comb begin
        cmd_err_d = accept && !ch_ok;
        done_d    = '0;
        pol_d     = pol_q;
        for (int v = 0; v < NCH; v++) begin
            state_d[v] = state_q[v];
            div_d[v]   = div_q[v];
            phase_d[v] = phase_q[v];
            dur_d[v]   = dur_q[v];
            amp_d[v]   = amp_q[v];
            if (stop_all) begin
                state_d[v] = S_IDLE;
                phase_d[v] = '0;
                pol_d[v]   = 1'b0;
            end else if (state_q[v] == S_PLAY) begin
                if (phase_q[v] == div_q[v]) begin
                    phase_d[v] = '0;
                    pol_d[v]   = ~pol_q[v];
                end else begin
                    phase_d[v] = phase_q[v] + 1'b1;
                end
                if (dur_q[v] == '0) begin
                    state_d[v] = S_IDLE;
                    done_d[v]  = 1'b1;
                end else begin
                    dur_d[v] = dur_q[v] - 1'b1;
                end
            end else if (accept && cmd_ch == CHW'(v)) begin
                state_d[v] = S_PLAY;
                div_d[v]   = cmd_div;
                dur_d[v]   = cmd_dur;
                amp_d[v]   = cmd_amp;
                phase_d[v] = '0;
                pol_d[v]   = 1'b0;
            end
        end
    end

    always_comb begin
        audio_ch = '0;
        busy     = '0;
        sum      = '0;
        mag      = '0;
        smp      = '0;
        for (int v = 0; v < NCH; v++) begin
            mag     = {1'b0, amp_q[v]};
            busy[v] = (state_q[v] == S_PLAY);
            if (state_q[v] == S_IDLE) begin
                smp = '0;
            end else if (pol_q[v]) begin
                smp = -mag;
            end else begin
                smp = mag;
            end
            audio_ch[v*AUD_W +: AUD_W] = smp;
            sum = sum + $signed({{(SW-AUD_W){smp[AUD_W-1]}}, smp});
        end
        if (sum > SAT_MAX) begin
            mix_d = {1'b0, {(AUD_W-1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            mix_d = {1'b1, {(AUD_W-1){1'b0}}};
        end else begin
            mix_d = sum[AUD_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NCH; v++) begin
                state_q[v] <= S_IDLE;
                div_q[v]   <= '0;
                phase_q[v] <= '0;
                dur_q[v]   <= '0;
                amp_q[v]   <= '0;
            end
            pol_q     <= '0;
            done_q    <= '0;
            cmd_err_q <= 1'b0;
            mix_q     <= '0;
        end else begin
            for (int v = 0; v < NCH; v++) begin
                state_q[v] <= state_d[v];
                div_q[v]   <= div_d[v];
                phase_q[v] <= phase_d[v];
                dur_q[v]   <= dur_d[v];
                amp_q[v]   <= amp_d[v];
            end
            pol_q     <= pol_d;
            done_q    <= done_d;
            cmd_err_q <= cmd_err_d;
            mix_q     <= mix_d;
        end
    end

    assign done      = done_q;
    assign cmd_err   = cmd_err_q;
    assign audio_mix = mix_q;

endmodule

// File: tb/tb_tone_synth_nch.sv
// tb/tb_tone_synth_nch.sv - self-checking bench for tone_synth_nch
// Three voices so that a 2-bit channel index can address a nonexistent voice.
module tb_tone_synth_nch;
    localparam int NCH   = 3;
    localparam int CHW   = 2;
    localparam int DIV_W = 22;
    localparam int DUR_W = 24;
    localparam int AUD_W = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CHW-1:0]       cmd_ch;
    logic [DIV_W-1:0]     cmd_div;
    logic [DUR_W-1:0]     cmd_dur;
    logic [AUD_W-2:0]     cmd_amp;
    logic                 stop_all;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       done;
    logic                 cmd_err;
    logic [NCH*AUD_W-1:0] audio_ch;
    logic [AUD_W-1:0]     audio_mix;

    tone_synth_nch #(.NCH(NCH), .DIV_W(DIV_W), .DUR_W(DUR_W), .AUD_W(AUD_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_div(cmd_div), .cmd_dur(cmd_dur), .cmd_amp(cmd_amp),
        .stop_all(stop_all), .busy(busy), .done(done), .cmd_err(cmd_err),
        .audio_ch(audio_ch), .audio_mix(audio_mix)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a voice is described by the cycle it started and its parameters.
    int cyc = 0;
    bit m_act   [NCH];
    int m_start [NCH];
    int m_div   [NCH];
    int m_dur   [NCH];
    int m_amp   [NCH];
    int m_err_cyc = -1;
    int exp_mix = 0;

    function automatic bit m_playing(int v);
        return m_act[v] && (cyc - m_start[v]) <= m_dur[v];
    endfunction

    function automatic int m_audio(int v);
        int e;
        e = cyc - m_start[v];
        if (!m_playing(v)) return 0;
        return ((e / (m_div[v] + 1)) % 2 == 1) ? -m_amp[v] : m_amp[v];
    endfunction

    function automatic logic [NCH-1:0] m_busy();
        logic [NCH-1:0] b;
        for (int v = 0; v < NCH; v++) b[v] = m_playing(v);
        return b;
    endfunction

    function automatic logic [NCH-1:0] m_done();
        logic [NCH-1:0] d;
        for (int v = 0; v < NCH; v++) d[v] = m_act[v] && (cyc - m_start[v]) == m_dur[v] + 1;
        return d;
    endfunction

    function automatic bit m_ready();
        if (stop_all) return 1'b0;
        if (int'(cmd_ch) >= NCH) return 1'b1;
        return !m_playing(int'(cmd_ch));
    endfunction

    function automatic int m_sat(int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    task automatic tick();
        int s;
        bit acc;
        s = 0;
        for (int v = 0; v < NCH; v++) s += m_audio(v);
        acc = cmd_valid && m_ready();
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int v = 0; v < NCH; v++) m_act[v] = 1'b0;
            exp_mix   = 0;
            m_err_cyc = -1;
        end else begin
            exp_mix = m_sat(s);
            if (stop_all) begin
                for (int v = 0; v < NCH; v++) m_act[v] = 1'b0;
            end else if (acc) begin
                if (int'(cmd_ch) < NCH) begin
                    m_act[cmd_ch]   = 1'b1;
                    m_start[cmd_ch] = cyc;
                    m_div[cmd_ch]   = int'(cmd_div);
                    m_dur[cmd_ch]   = int'(cmd_dur);
                    m_amp[cmd_ch]   = int'(cmd_amp);
                end else begin
                    m_err_cyc = cyc;
                end
            end
        end
        #1;
    endtask

    task automatic set_cmd(int ch, int dv, int du, int am);
        cmd_valid = 1'b1;
        cmd_ch    = CHW'(ch);
        cmd_div   = DIV_W'(dv);
        cmd_dur   = DUR_W'(du);
        cmd_amp   = (AUD_W-1)'(am);
        #1;
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        stop_all  = 1'b0;
        for (int i = 0; i < 300 && m_busy() != '0; i++) tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; stop_all = 1'b0;
        cmd_ch = '0; cmd_div = '0; cmd_dur = '0; cmd_amp = '0;
        repeat (3) tick();
        tests++; if (busy !== '0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== '0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", cmd_err); end
        tests++; if (audio_ch !== '0) begin fails++; $display("FAIL reset_audio got %h want 0", audio_ch); end
        tests++; if (audio_mix !== '0) begin fails++; $display("FAIL reset_mix got %h want 0", audio_mix); end
        rst = 1'b0;
        set_cmd(0, 2, 30, 500); tick();
        set_cmd(1, 3, 30, 700); tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        tests++; if (busy !== 3'b011) begin fails++; $display("FAIL reset_preplay_busy got %b want 011", busy); end
        rst = 1'b1;
        tick();
        tests++; if (busy !== '0) begin fails++; $display("FAIL midreset_busy got %b want 0", busy); end
        tests++; if (audio_ch !== '0) begin fails++; $display("FAIL midreset_audio got %h want 0", audio_ch); end
        tests++; if (audio_mix !== '0) begin fails++; $display("FAIL midreset_mix got %h want 0", audio_mix); end
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            tests++; if (done !== '0) begin fails++; $display("FAIL midreset_nodone cyc %0d got %b want 0", i, done); end
        end
    endtask

    task automatic test_tone();
        int busy_cnt;
        int done_at;
        logic [AUD_W-1:0] want;
        busy_cnt = 0; done_at = -1;
        set_cmd(0, 3, 15, 1000);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL tone_ready got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            want = (i < 16) ? ((((i / 4) % 2) == 1) ? AUD_W'(-1000) : AUD_W'(1000)) : '0;
            tests++;
            if (audio_ch[0 +: AUD_W] !== want) begin
                fails++; $display("FAIL tone_audio e=%0d got %0d want %0d", i, $signed(audio_ch[0 +: AUD_W]), $signed(want));
            end
            tests++;
            if (audio_mix !== AUD_W'(exp_mix)) begin
                fails++; $display("FAIL tone_mix e=%0d got %0d want %0d", i, $signed(audio_mix), exp_mix);
            end
            if (busy[0]) busy_cnt++;
            if (done[0]) done_at = i;
            tick();
        end
        tests++; if (busy_cnt != 16) begin fails++; $display("FAIL tone_busy_len got %0d want 16", busy_cnt); end
        tests++; if (done_at != 16) begin fails++; $display("FAIL tone_done_at got %0d want 16", done_at); end
    endtask

    task automatic test_back_to_back();
        int acc_at;
        acc_at = -1;
        set_cmd(0, 1, 5, 200); tick();
        set_cmd(0, 0, 3, 300);
        for (int i = 0; i < 20 && acc_at < 0; i++) begin
            tests++;
            if (cmd_ready !== m_ready()) begin
                fails++; $display("FAIL hold_ready e=%0d got %b want %b", i, cmd_ready, m_ready());
            end
            if (cmd_ready === 1'b1) begin
                acc_at = i;
                tests++; if (done[0] !== 1'b1) begin fails++; $display("FAIL hold_done got %b want 1", done[0]); end
            end
            tick();
        end
        cmd_valid = 1'b0;
        tests++; if (acc_at != 6) begin fails++; $display("FAIL hold_accept_at got %0d want 6", acc_at); end
        tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL hold_reload_busy got %b want 1", busy[0]); end
        drain();
    endtask

    task automatic run_mix(int n, inout int pos_sat, inout int zero_ov, inout int neg_sat);
        for (int i = 0; i < n; i++) begin
            tests++;
            if (audio_mix !== AUD_W'(exp_mix)) begin
                fails++; $display("FAIL mix cyc=%0d got %0d want %0d", cyc, $signed(audio_mix), exp_mix);
            end
            if (exp_mix == 32767) pos_sat++;
            if (exp_mix == -32768) neg_sat++;
            if (exp_mix == 0 && busy == 3'b011) zero_ov++;
            tick();
        end
    endtask

    task automatic test_mix();
        int pos_sat, zero_ov, neg_sat;
        pos_sat = 0; zero_ov = 0; neg_sat = 0;
        set_cmd(0, 9, 30, 32767); tick();
        set_cmd(1, 9, 30, 32767); tick();
        cmd_valid = 1'b0;
        run_mix(36, pos_sat, zero_ov, neg_sat);
        set_cmd(0, 0, 10, 32767); tick();
        set_cmd(1, 0, 10, 32767); tick();
        cmd_valid = 1'b0;
        run_mix(14, pos_sat, zero_ov, neg_sat);
        set_cmd(0, 20, 40, 32767); tick();
        set_cmd(1, 20, 40, 32767); tick();
        set_cmd(2, 20, 40, 32767); tick();
        cmd_valid = 1'b0;
        run_mix(46, pos_sat, zero_ov, neg_sat);
        tests++; if (pos_sat == 0) begin fails++; $display("FAIL mix_pos_sat_seen got 0 want >0"); end
        tests++; if (zero_ov == 0) begin fails++; $display("FAIL mix_cancel_seen got 0 want >0"); end
        tests++; if (neg_sat == 0) begin fails++; $display("FAIL mix_neg_sat_seen got 0 want >0"); end
        drain();
    endtask

    task automatic test_bad_ch();
        set_cmd(1, 4, 20, 100); tick();
        set_cmd(3, 1, 1, 1);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL badch_ready got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        tests++; if (cmd_err !== 1'b1) begin fails++; $display("FAIL badch_err got %b want 1", cmd_err); end
        tests++; if (busy !== 3'b010) begin fails++; $display("FAIL badch_busy got %b want 010", busy); end
        tick();
        tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL badch_err_pulse got %b want 0", cmd_err); end
        drain();
    endtask

    task automatic test_stop_all();
        set_cmd(0, 2, 50, 400); tick();
        set_cmd(1, 3, 50, 400); tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        stop_all = 1'b1;
        set_cmd(2, 1, 5, 100);
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL stop_ready got %b want 0", cmd_ready); end
        tick();
        stop_all = 1'b0; cmd_valid = 1'b0;
        tests++; if (busy !== '0) begin fails++; $display("FAIL stop_busy got %b want 0", busy); end
        tests++; if (audio_ch !== '0) begin fails++; $display("FAIL stop_audio got %h want 0", audio_ch); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (done !== '0) begin fails++; $display("FAIL stop_nodone got %b want 0", done); end
        end
        set_cmd(0, 0, 2, 50); tick();
        cmd_valid = 1'b0;
        tick(); tick();
        stop_all = 1'b1;
        tick();
        stop_all = 1'b0;
        tests++; if (done !== '0) begin fails++; $display("FAIL stop_finish_done got %b want 0", done); end
        tests++; if (busy !== '0) begin fails++; $display("FAIL stop_finish_busy got %b want 0", busy); end
        tick();
        tests++; if (done !== '0) begin fails++; $display("FAIL stop_finish_late got %b want 0", done); end
    endtask

    task automatic test_short();
        set_cmd(2, 0, 0, 5); tick();
        cmd_valid = 1'b0;
        tests++; if (audio_ch[2*AUD_W +: AUD_W] !== 16'd5) begin fails++; $display("FAIL short_audio got %0d want 5", $signed(audio_ch[2*AUD_W +: AUD_W])); end
        tests++; if (busy !== 3'b100) begin fails++; $display("FAIL short_busy got %b want 100", busy); end
        tick();
        tests++; if (busy !== '0) begin fails++; $display("FAIL short_idle got %b want 0", busy); end
        tests++; if (done !== 3'b100) begin fails++; $display("FAIL short_done got %b want 100", done); end
        tests++; if (audio_ch !== '0) begin fails++; $display("FAIL short_silent got %h want 0", audio_ch); end
        tick();
        tests++; if (done !== '0) begin fails++; $display("FAIL short_done_pulse got %b want 0", done); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_ch    = CHW'($urandom_range(0, 3));
            cmd_div   = DIV_W'($urandom_range(0, 5));
            cmd_dur   = DUR_W'($urandom_range(0, 20));
            cmd_amp   = (AUD_W-1)'($urandom_range(0, 32767));
            stop_all  = ($urandom_range(0, 99) < 3);
            #1;
            tests++;
            if (cmd_ready !== m_ready()) begin fails++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, cmd_ready, m_ready()); end
            tick();
            tests++;
            if (busy !== m_busy()) begin fails++; $display("FAIL rnd_busy cyc=%0d got %b want %b", cyc, busy, m_busy()); end
            tests++;
            if (done !== m_done()) begin fails++; $display("FAIL rnd_done cyc=%0d got %b want %b", cyc, done, m_done()); end
            tests++;
            if (cmd_err !== (m_err_cyc == cyc)) begin fails++; $display("FAIL rnd_err cyc=%0d got %b want %b", cyc, cmd_err, m_err_cyc == cyc); end
            for (int v = 0; v < NCH; v++) begin
                tests++;
                if (audio_ch[v*AUD_W +: AUD_W] !== AUD_W'(m_audio(v))) begin
                    fails++; $display("FAIL rnd_audio%0d cyc=%0d got %0d want %0d", v, cyc, $signed(audio_ch[v*AUD_W +: AUD_W]), m_audio(v));
                end
            end
            tests++;
            if (audio_mix !== AUD_W'(exp_mix)) begin fails++; $display("FAIL rnd_mix cyc=%0d got %0d want %0d", cyc, $signed(audio_mix), exp_mix); end
        end
        drain();
    endtask

    initial begin
        for (int v = 0; v < NCH; v++) begin
            m_act[v] = 1'b0; m_start[v] = 0; m_div[v] = 0; m_dur[v] = 0; m_amp[v] = 0;
        end
        test_reset();
        test_tone();
        test_back_to_back();
        test_mix();
        test_bad_ch();
        test_stop_all();
        test_short();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
